code_entry_capture: RTL and testbench

//  Keypad-side writer for the door-code checker: captures up to 6 BCD digits into m0..m5 and
//  the digit count into d, then holds them stable while the checker drives porta.

---
 rtl/code_entry_capture_pkg.sv | 33 +++
 rtl/code_entry_capture_cycle_timer.sv | 34 +++
 rtl/code_entry_capture.sv | 181 ++++++++++++++++++
 tb/tb_code_entry_capture.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/code_entry_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : code_entry_capture_pkg
//  Description : Shared types and constants for the keypad code-entry writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package code_entry_capture_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ENTRY   = 2'd1,
      ST_PRESENT = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   // Largest legal BCD digit value
   localparam int BCD_MAX = 9;

   // Number of digit slots in the register bank
   localparam int NDIG = 6;

   // Largest of three interval lengths, used to size the shared timer
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/code_entry_capture_cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : code_entry_capture_cycle_timer
//  Description : Up-counter with synchronous clear and a terminal-count flag
//                that is high during the last cycle of a LIMIT-cycle interval.
//  Revision    : 1.0 - initial release
// ============================================================================
module code_entry_capture_cycle_timer #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         tc
);

   logic [W-1:0] count;

   // Count enabled cycles since the last clear
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   // Flag the final cycle of the interval (count runs 0 .. limit-1)
   assign tc = en && (count == (limit - W'(1)));

endmodule
`default_nettype wire

// File: rtl/code_entry_capture.sv
`default_nettype none
// ============================================================================
//  Module      : code_entry_capture
//  Description : Keypad-side writer for the door-code checker. Captures up to
//                six BCD digits, presents them to the comparator for a fixed
//                hold window, tracks failed attempts and locks the keypad out.
//  Revision    : 1.0 - initial release
// ============================================================================
module code_entry_capture
   import code_entry_capture_pkg::*;
#(
   parameter int DW       = 4,
   parameter int HOLD     = 4,
   parameter int TIMEOUT  = 1000,
   parameter int MAX_FAIL = 3,
   parameter int LOCK_CYC = 5000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] key_val,
   input  logic          key_stb,
   input  logic          key_enter,
   input  logic          key_clear,
   input  logic          porta_in,
   output logic [DW-1:0] m0,
   output logic [DW-1:0] m1,
   output logic [DW-1:0] m2,
   output logic [DW-1:0] m3,
   output logic [DW-1:0] m4,
   output logic [DW-1:0] m5,
   output logic [2:0]    d,
   output logic          check,
   output logic          locked,
   output logic [1:0]    fail_cnt,
   output logic          key_err
);

   // One counter serves all three intervals, so size it for the longest
   localparam int TMAX = max3(TIMEOUT, HOLD, LOCK_CYC);
   localparam int CW   = $clog2(TMAX + 1);
   localparam logic [DW-1:0] DIGIT_LIM = DW'(BCD_MAX);

   state_t        state;
   logic [DW-1:0] mem [NDIG];

   logic          key_ok;
   logic          entry_enter;
   logic          entry_accept;
   logic          any_strobe;
   logic          tmr_clear;
   logic          tmr_en;
   logic [CW-1:0] tmr_limit;
   logic          tmr_tc;

   // Decode strobes with clear > enter > stb priority inside ENTRY
   always_comb begin
      key_ok       = key_stb && (key_val <= DIGIT_LIM);
      entry_enter  = !key_clear && key_enter && (d != 3'd0);
      entry_accept = !key_clear && !entry_enter && key_ok && (d < 3'(NDIG));
      any_strobe   = key_stb || key_enter || key_clear;
   end

   // Select the interval length for the current state and restart the timer
   // on every state change and on every accepted digit
   always_comb begin
      tmr_limit = CW'(TIMEOUT);
      case (state)
         ST_PRESENT: tmr_limit = CW'(HOLD);
         ST_LOCKOUT: tmr_limit = CW'(LOCK_CYC);
         default:    tmr_limit = CW'(TIMEOUT);
      endcase
      tmr_en    = (state != ST_IDLE);
      tmr_clear = (state == ST_IDLE) || tmr_tc ||
                  ((state == ST_ENTRY) && (key_clear || entry_enter || entry_accept));
   end

   code_entry_capture_cycle_timer #(
      .W (CW)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (tmr_clear),
      .en    (tmr_en),
      .limit (tmr_limit),
      .tc    (tmr_tc)
   );

   // Main controller: state, digit bank and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         d        <= 3'd0;
         check    <= 1'b0;
         locked   <= 1'b0;
         fail_cnt <= 2'd0;
         key_err  <= 1'b0;
         for (int i = 0; i < NDIG; i++) mem[i] <= '0;
      end else begin
         key_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               // enter/clear carry no meaning without a partial code
               if (key_stb) begin
                  if (key_ok) begin
                     mem[0] <= key_val;
                     d      <= 3'd1;
                     state  <= ST_ENTRY;
                  end else begin
                     key_err <= 1'b1;
                  end
               end
            end

            ST_ENTRY: begin
               if (key_clear) begin
                  for (int i = 0; i < NDIG; i++) mem[i] <= '0;
                  d     <= 3'd0;
                  state <= ST_IDLE;
               end else if (entry_enter) begin
                  check <= 1'b1;
                  state <= ST_PRESENT;
               end else begin
                  if (entry_accept) begin
                     mem[d] <= key_val;
                     d      <= d + 3'd1;
                  end else begin
                     if (key_stb) key_err <= 1'b1;
                     // A rejected digit does not count as activity
                     if (tmr_tc) begin
                        for (int i = 0; i < NDIG; i++) mem[i] <= '0;
                        d     <= 3'd0;
                        state <= ST_IDLE;
                     end
                  end
               end
            end

            ST_PRESENT: begin
               if (any_strobe) key_err <= 1'b1;
               // Comparator result is only trusted on the last hold cycle
               if (tmr_tc) begin
                  check <= 1'b0;
                  d     <= 3'd0;
                  for (int i = 0; i < NDIG; i++) mem[i] <= '0;
                  if (porta_in) begin
                     fail_cnt <= 2'd0;
                     state    <= ST_IDLE;
                  end else if ((int'(fail_cnt) + 1) >= MAX_FAIL) begin
                     fail_cnt <= 2'(MAX_FAIL);
                     locked   <= 1'b1;
                     state    <= ST_LOCKOUT;
                  end else begin
                     fail_cnt <= fail_cnt + 2'd1;
                     state    <= ST_IDLE;
                  end
               end
            end

            ST_LOCKOUT: begin
               if (any_strobe) key_err <= 1'b1;
               if (tmr_tc) begin
                  locked   <= 1'b0;
                  fail_cnt <= 2'd0;
                  state    <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign m0 = mem[0];
   assign m1 = mem[1];
   assign m2 = mem[2];
   assign m3 = mem[3];
   assign m4 = mem[4];
   assign m5 = mem[5];

endmodule
`default_nettype wire

// File: tb/tb_code_entry_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_code_entry_capture
//  Description : Directed self-checking bench for code_entry_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_code_entry_capture;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key_val = 4'd0;
   logic       key_stb = 1'b0;
   logic       key_enter = 1'b0;
   logic       key_clear = 1'b0;
   logic       porta_in = 1'b0;
   logic [3:0] m0, m1, m2, m3, m4, m5;
   logic [2:0] d;
   logic       check;
   logic       locked;
   logic [1:0] fail_cnt;
   logic       key_err;

   int n_chk  = 0;
   int n_fail = 0;

   code_entry_capture #(
      .DW       (4),
      .HOLD     (4),
      .TIMEOUT  (20),
      .MAX_FAIL (3),
      .LOCK_CYC (50)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_val   (key_val),
      .key_stb   (key_stb),
      .key_enter (key_enter),
      .key_clear (key_clear),
      .porta_in  (porta_in),
      .m0        (m0),
      .m1        (m1),
      .m2        (m2),
      .m3        (m3),
      .m4        (m4),
      .m5        (m5),
      .d         (d),
      .check     (check),
      .locked    (locked),
      .fail_cnt  (fail_cnt),
      .key_err   (key_err)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just past the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] v);
      key_val = v;
      key_stb = 1'b1;
      tick();
      key_stb = 1'b0;
   endtask

   task automatic enter();
      key_enter = 1'b1;
      tick();
      key_enter = 1'b0;
   endtask

   function automatic logic [31:0] mall();
      return {8'h00, m0, m1, m2, m3, m4, m5};
   endfunction

   initial begin
      // ---- reset state
      tick();
      tick();
      chk("rst_d", 32'(d), 0);
      chk("rst_m", mall(), 0);
      chk("rst_check", 32'(check), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_fail", 32'(fail_cnt), 0);
      chk("rst_err", 32'(key_err), 0);
      rst = 1'b0;
      tick();

      // ---- full six-digit code accepted
      press(4'd1);
      chk("first_d", 32'(d), 1);
      chk("first_m0", 32'(m0), 1);
      press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(4'd6);
      chk("full_d", 32'(d), 6);
      chk("full_m", mall(), 32'h00123456);
      porta_in = 1'b1;
      enter();
      chk("pres_c1", 32'(check), 1);
      press(4'd5);                       // strobe while presenting
      chk("pres_err", 32'(key_err), 1);
      chk("pres_c2", 32'(check), 1);
      chk("pres_frozen", mall(), 32'h00123456);
      tick();
      chk("pres_errclr", 32'(key_err), 0);
      chk("pres_c3", 32'(check), 1);
      tick();
      chk("pres_c4", 32'(check), 1);
      tick();
      chk("pass_check", 32'(check), 0);
      chk("pass_d", 32'(d), 0);
      chk("pass_m", mall(), 0);
      chk("pass_fail", 32'(fail_cnt), 0);
      porta_in = 1'b0;

      // ---- rejected keys
      press(4'd7);
      press(4'd12);
      chk("bad_err", 32'(key_err), 1);
      chk("bad_d", 32'(d), 1);
      press(4'd1);
      chk("err_pulse", 32'(key_err), 0);
      press(4'd2); press(4'd3); press(4'd4); press(4'd5);
      chk("full2_d", 32'(d), 6);
      press(4'd8);
      chk("ovf_err", 32'(key_err), 1);
      chk("ovf_d", 32'(d), 6);
      chk("ovf_m", mall(), 32'h00712345);
      key_clear = 1'b1;
      tick();
      key_clear = 1'b0;
      chk("clr_d", 32'(d), 0);
      chk("clr_m", mall(), 0);

      // ---- three failed attempts lead to lockout
      for (int a = 1; a <= 3; a++) begin
         press(4'd0);
         press(4'd1);
         chk("fail_entry", {d, m0, m1}, {3'd2, 4'd0, 4'd1});
         enter();
         repeat (4) tick();
         chk("fail_d", 32'(d), 0);
         chk("fail_cnt", 32'(fail_cnt), 32'(a));
         chk("fail_lock", 32'(locked), (a == 3) ? 1 : 0);
      end
      press(4'd3);
      chk("lock_err", 32'(key_err), 1);
      chk("lock_d", 32'(d), 0);
      repeat (48) tick();
      chk("lock_hold", 32'(locked), 1);
      tick();
      chk("lock_end", 32'(locked), 0);
      chk("lock_fail0", 32'(fail_cnt), 0);

      // ---- idle timeout discards a partial code
      press(4'd3);
      chk("to_start", {d, m0}, {3'd1, 4'd3});
      repeat (19) tick();
      chk("to_before", 32'(d), 1);
      tick();
      chk("to_d", 32'(d), 0);
      chk("to_m0", 32'(m0), 0);
      enter();                           // ignored in IDLE
      chk("idle_enter", {check, key_err}, 2'b00);

      // ---- one failure to make fail_cnt non-zero
      press(4'd9);
      enter();
      repeat (4) tick();
      chk("f1_cnt", 32'(fail_cnt), 1);

      // ---- enter and digit in the same cycle: digit dropped
      press(4'd4);
      key_val   = 4'd7;
      key_stb   = 1'b1;
      key_enter = 1'b1;
      tick();
      key_stb   = 1'b0;
      key_enter = 1'b0;
      chk("both_check", 32'(check), 1);
      chk("both_d", 32'(d), 1);
      chk("both_m", mall(), 32'h00400000);
      chk("both_err", 32'(key_err), 0);

      // ---- reset in the middle of the hold window
      tick();
      rst = 1'b1;
      tick();
      chk("mrst_out", {29'd0, d, check, locked, key_err}, 0);
      chk("mrst_m", mall(), 0);
      chk("mrst_fail", 32'(fail_cnt), 0);
      rst = 1'b0;
      tick();
      press(4'd2);
      chk("post_rst", {d, m0}, {3'd1, 4'd2});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
